r8mbe_ppacc: RTL and testbench

- Sequential partial-product accumulator directly downstream of the radix-8 MBE Booth selector unit.
- Captures one full set of N_PP partial products, plus their negate flags, through a valid/ready handshake.
- Sums them one per cycle with 3-bit relative weighting and returns the product through a valid/ready handshake.
- Trades latency for area against a full Dadda tree.

---
 rtl/r8mbe_ppacc.sv | 119 +++++++++++
 tb/tb_r8mbe_ppacc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r8mbe_ppacc.sv
// Radix-8 MBE partial-product accumulator: sums N_PP weighted PPs sequentially.
// Define R8MBE_PPACC_DUAL_ADD_EN to add two partial products per ACCUM cycle.
module r8mbe_ppacc #(
    parameter  int WIDTH_PPG = 14,
    parameter  int N_PP      = 8,
    localparam int PROD_W    = WIDTH_PPG + 3*(N_PP-1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N_PP*WIDTH_PPG-1:0] pp_i,
    input  logic [N_PP-1:0]           pp_neg_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PROD_W-1:0]         prod_o,
    output logic                      busy_o
);

    localparam int SEL_W = (N_PP > 2) ? $clog2(N_PP) : 1;

`ifdef R8MBE_PPACC_DUAL_ADD_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_PP - STEP);
    localparam logic [SEL_W-1:0] IDX_STEP = SEL_W'(STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                r_state;
    logic [N_PP*WIDTH_PPG-1:0] r_pp;
    logic [N_PP-1:0]           r_neg;
    logic [PROD_W-1:0]         r_acc;
    logic [SEL_W-1:0]          r_idx;

    logic [WIDTH_PPG-1:0]      w_pp [N_PP];
    logic [SEL_W+1:0]          w_sh0;
    logic [PROD_W-1:0]         w_add;

    // Sign-extend a PP, apply its +1 negate correction, then weight it.
    function automatic logic [PROD_W-1:0] f_term(
        input logic [WIDTH_PPG-1:0] pp,
        input logic                 neg,
        input logic [SEL_W+1:0]     sh
    );
        logic [PROD_W-1:0] v;
        v = {{(PROD_W-WIDTH_PPG){pp[WIDTH_PPG-1]}}, pp}
          + {{(PROD_W-1){1'b0}}, neg};
        return v << sh;
    endfunction

    for (genvar g = 0; g < N_PP; g++) begin : g_unpack
        assign w_pp[g] = r_pp[g*WIDTH_PPG +: WIDTH_PPG];
    end

    // Shift for PP[idx] is 3*idx, formed as idx + 2*idx.
    assign w_sh0 = {2'b00, r_idx} + {1'b0, r_idx, 1'b0};

`ifdef R8MBE_PPACC_DUAL_ADD_EN
    logic [SEL_W-1:0] w_idx1;
    logic [SEL_W+1:0] w_sh1;

    assign w_idx1 = r_idx + SEL_W'(1);
    assign w_sh1  = w_sh0 + (SEL_W+2)'(3);
    assign w_add  = f_term(w_pp[r_idx], r_neg[r_idx], w_sh0)
                  + f_term(w_pp[w_idx1], r_neg[w_idx1], w_sh1);
`else
    assign w_add  = f_term(w_pp[r_idx], r_neg[r_idx], w_sh0);
`endif

    // Control FSM and accumulator datapath; reset aborts any operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_pp    <= '0;
            r_neg   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_pp    <= pp_i;
                        r_neg   <= pp_neg_i;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_add;
                    r_idx <= r_idx + IDX_STEP;
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign prod_o      = r_acc;

endmodule

// File: tb/tb_r8mbe_ppacc.sv
// Scoreboard bench for r8mbe_ppacc: driver pushes expected products,
// a negedge monitor pops and compares on every output handshake.
module tb_r8mbe_ppacc;

    localparam int W  = 14;
    localparam int N  = 8;
    localparam int PW = W + 3*(N-1);

`ifdef R8MBE_PPACC_DUAL_ADD_EN
    localparam int LAT = N/2;
`else
    localparam int LAT = N;
`endif

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [N*W-1:0]  pp_i;
    logic [N-1:0]    pp_neg_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [PW-1:0]   prod_o;
    logic            busy_o;

    int nchk = 0;
    int nerr = 0;
    int npush = 0;
    int npop = 0;

    logic [PW-1:0] sb [$];

    r8mbe_ppacc #(.WIDTH_PPG(W), .N_PP(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pp_i        (pp_i),
        .pp_neg_i    (pp_neg_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .prod_o      (prod_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack8(
        input logic [W-1:0] a7, input logic [W-1:0] a6,
        input logic [W-1:0] a5, input logic [W-1:0] a4,
        input logic [W-1:0] a3, input logic [W-1:0] a2,
        input logic [W-1:0] a1, input logic [W-1:0] a0);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Reference: signed sum of (PP_k + neg_k) * 8^k, wrapped to PW bits.
    function automatic logic [PW-1:0] model(input logic [N*W-1:0] pp,
                                           input logic [N-1:0] neg);
        longint s = 0;
        logic signed [W-1:0] p;
        for (int k = 0; k < N; k++) begin
            p = pp[k*W +: W];
            s = s + (longint'(p) + longint'(neg[k])) * (longint'(1) << (3*k));
        end
        return s[PW-1:0];
    endfunction

    // Monitor: compare every accepted product against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            npop++;
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(prod_o), 64'hDEAD);
            end else begin
                check("prod", 64'(prod_o), 64'(sb.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) check("ready_timeout", 64'(n), 64'd0);
    endtask

    task automatic send(input logic [N*W-1:0] pp, input logic [N-1:0] neg,
                        input logic [PW-1:0] exp);
        @(posedge clk);
        #1;
        in_valid_i = 1'b1;
        pp_i       = pp;
        pp_neg_i   = neg;
        wait_ready();
        @(posedge clk);
        sb.push_back(exp);
        npush++;
        #1;
        in_valid_i = 1'b0;
    endtask

    // Counts accept-to-valid cycles; call right after send().
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid_o && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid_o) check("valid_timeout", 64'(n), 64'd0);
    endtask

    logic [N*W-1:0] bv [3];
    logic [N-1:0]   bn [3];
    time            tacc [3];

    initial begin
        int lat;
        int cnt;
        logic [PW-1:0] held;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        pp_i        = '0;
        pp_neg_i    = '0;
        out_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_prod", 64'(prod_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Zeros
        send('0, '0, 35'h000000000);
        wait_valid(lat);
        check("latency_zeros", 64'(lat), 64'(LAT));

        // Negation correction
        send(pack8(0, 0, 0, 0, 0, 0, 0, 14'h3FFA), 8'h01, 35'h7FFFFFFFB);
        wait_valid(lat);
        check("latency_neg", 64'(lat), 64'(LAT));
        check("done_busy", 64'(busy_o), 64'd1);
        check("done_in_ready", 64'(in_ready_o), 64'd0);

        // Weighting
        send(pack8(14'h1FFF, 0, 0, 0, 0, 0, 14'h0001, 0), 8'h00,
             35'h3FFE00008);
        wait_valid(lat);

        // Backpressure with a pending new set
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        send(pack8(0, 0, 0, 0, 0, 14'h0005, 0, 0), 8'h00, 35'h000000140);
        wait_valid(lat);
        held = prod_o;
        check("bp_prod_first", 64'(held), 64'h140);
        #1;
        in_valid_i = 1'b1;
        pp_i       = pack8(0, 0, 0, 0, 0, 0, 0, 14'h2000);
        pp_neg_i   = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_prod_stable", 64'(prod_o), 64'(held));
            check("bp_in_ready", 64'(in_ready_o), 64'd0);
            check("bp_out_valid", 64'(out_valid_o), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", 64'(in_ready_o), 64'd1);
        check("bp_idle_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        sb.push_back(35'h7FFFFE000);
        npush++;
        #1;
        in_valid_i = 1'b0;
        wait_valid(lat);
        check("latency_bp", 64'(lat), 64'(LAT));

        // Mid-operation reset on the third ACCUM cycle
        send(pack8(14'h0123, 14'h0456, 14'h0789, 14'h0ABC,
                   14'h1DEF, 14'h0F0F, 14'h1234, 14'h0777), 8'hA5,
             '0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        void'(sb.pop_back());
        npush--;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready_o), 64'd1);
        check("abort_out_valid", 64'(out_valid_o), 64'd0);
        check("abort_prod", 64'(prod_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid_o) cnt++;
        end
        check("abort_no_prod", 64'(cnt), 64'd0);

        // Back-to-back with in_valid and out_ready held high
        bv[0] = pack8(14'h1FFF, 14'h2000, 14'h0001, 14'h3FFF,
                      14'h1234, 14'h2ABC, 14'h0555, 14'h3001);
        bn[0] = 8'h3C;
        bv[1] = pack8(14'h2001, 14'h0F00, 14'h3333, 14'h0042,
                      14'h1111, 14'h3E00, 14'h0007, 14'h1F80);
        bn[1] = 8'hC3;
        bv[2] = pack8(14'h3FFE, 14'h0100, 14'h2468, 14'h1357,
                      14'h3CCC, 14'h0003, 14'h2222, 14'h0999);
        bn[2] = 8'h5A;
        @(posedge clk);
        #1;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pp_i     = bv[i];
            pp_neg_i = bn[i];
            wait_ready();
            @(posedge clk);
            sb.push_back(model(bv[i], bn[i]));
            npush++;
            tacc[i] = $time;
            #1;
        end
        in_valid_i = 1'b0;
        check("b2b_spacing01", 64'((tacc[1] - tacc[0]) / 10), 64'(LAT + 2));
        check("b2b_spacing12", 64'((tacc[2] - tacc[1]) / 10), 64'(LAT + 2));

        cnt = 0;
        while (sb.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("pop_count", 64'(npop), 64'(npush));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
